clk_div_prog: RTL and testbench

//  Runtime-programmable integer clock divider with a divisor-load handshake.

---
 rtl/clk_div_prog.sv | 101 ++++++++++
 tb/tb_clk_div_prog.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a divisor-load handshake.
// Produces a registered divided clock, a period-end tick strobe and load ack/err pulses.
module clk_div_prog #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DEF_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic             clk_out,
   output logic             tick
);

   localparam int unsigned HW = CNT_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] n, n_nx;
   logic [CNT_W-1:0] pend_val, pend_val_nx;
   logic             pend, pend_nx;
   logic             clk_out_nx, tick_nx, ack_nx, err_nx;
   logic             load_ok, load_bad, at_end, apply;
   logic [HW-1:0]    half_nx;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         n        <= CNT_W'(DEF_DIV);
         pend_val <= '0;
         pend     <= 1'b0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
         div_ack  <= 1'b0;
         div_err  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         n        <= n_nx;
         pend_val <= pend_val_nx;
         pend     <= pend_nx;
         clk_out  <= clk_out_nx;
         tick     <= tick_nx;
         div_ack  <= ack_nx;
         div_err  <= err_nx;
      end
   end

   // Next-state, counter and handshake logic
   always_comb begin
      state_nx    = state;
      cnt_nx      = '0;
      n_nx        = n;
      pend_val_nx = pend_val;
      pend_nx     = pend;
      clk_out_nx  = 1'b0;
      tick_nx     = 1'b0;
      ack_nx      = 1'b0;
      err_nx      = 1'b0;
      load_ok     = 1'b0;
      load_bad    = 1'b0;
      at_end      = 1'b0;
      apply       = 1'b0;
      half_nx     = '0;

      load_ok  = div_load && (div_val >= CNT_W'(2));
      load_bad = div_load && !load_ok;
      at_end   = (state == RUN) && (cnt == n - CNT_W'(1));

      // A rejected load on an apply edge defers the apply so ack and err never coincide
      apply = !load_bad && (((state == IDLE) && pend) || (at_end && (pend || load_ok)));

      state_nx    = en ? RUN : IDLE;
      pend_val_nx = load_ok ? div_val : pend_val;
      n_nx        = apply ? pend_val_nx : n;
      pend_nx     = apply ? 1'b0 : (pend || load_ok);

      if (!en || (state == IDLE) || at_end) begin
         cnt_nx = '0;
      end else begin
         cnt_nx = cnt + CNT_W'(1);
      end

      half_nx    = ({1'b0, n_nx} + HW'(1)) >> 1;
      clk_out_nx = en && ({1'b0, cnt_nx} < half_nx);
      tick_nx    = en && (cnt_nx == n_nx - CNT_W'(1));
      ack_nx     = apply;
      err_nx     = load_bad;
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog: period shape, tick timing,
// load handshake (ack/err, last-wins, boundary apply), idle abort and reset.
module tb_clk_div_prog;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [CNT_W-1:0] div_val;
   logic             div_load;
   logic             div_ack;
   logic             div_err;
   logic             clk_out;
   logic             tick;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .div_val  (div_val),
      .div_load (div_load),
      .div_ack  (div_ack),
      .div_err  (div_err),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      en       = 1'b0;
      div_load = 1'b0;
      div_val  = '0;
      step_clk();
      reset = 1'b0;
   endtask

   // Run cycles with the expected waveform for divisor n; start is the phase of the first cycle
   task automatic check_period(input string tag, input int n, input int cycles, input int start);
      for (int i = 0; i < cycles; i++) begin
         int k;
         k = (start + i) % n;
         step_clk();
         chk({tag, "_clk"},  32'(clk_out), 32'(k < (n + 1) / 2));
         chk({tag, "_tick"}, 32'(tick),    32'(k == n - 1));
         chk({tag, "_ack"},  32'(div_ack), 32'd0);
         chk({tag, "_err"},  32'(div_err), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
      @(negedge clk);

      // 1) reset state, then default divide-by-4
      do_reset();
      chk("rst_clk",  32'(clk_out), 32'd0);
      chk("rst_tick", 32'(tick),    32'd0);
      chk("rst_ack",  32'(div_ack), 32'd0);
      chk("rst_err",  32'(div_err), 32'd0);
      en = 1'b1;
      check_period("t1", 4, 12, 0);

      // 2) load 5 while idle, ack on the following cycle
      do_reset();
      div_load = 1'b1; div_val = 8'd5;
      step_clk();
      div_load = 1'b0;
      chk("t2_ack_early", 32'(div_ack), 32'd0);
      step_clk();
      chk("t2_ack",      32'(div_ack), 32'd1);
      chk("t2_err",      32'(div_err), 32'd0);
      chk("t2_idle_clk", 32'(clk_out), 32'd0);
      step_clk();
      chk("t2_ack_once", 32'(div_ack), 32'd0);
      en = 1'b1;
      check_period("t2", 5, 10, 0);

      // 3) load 3 at cnt=1 of an N=4 period; applies at the boundary
      do_reset();
      en = 1'b1;
      check_period("t3a", 4, 2, 0);
      div_load = 1'b1; div_val = 8'd3;
      step_clk();
      div_load = 1'b0;
      chk("t3_ack_mid", 32'(div_ack), 32'd0);
      chk("t3_clk_mid", 32'(clk_out), 32'd0);
      check_period("t3b", 4, 1, 3);
      step_clk();
      chk("t3_ack",  32'(div_ack), 32'd1);
      chk("t3_clk",  32'(clk_out), 32'd1);
      chk("t3_tick", 32'(tick),    32'd0);
      check_period("t3c", 3, 8, 1);

      // 4) invalid loads 1 and 0 raise div_err, period stays 3
      div_load = 1'b1; div_val = 8'd1;
      step_clk();
      chk("t4_err1", 32'(div_err), 32'd1);
      chk("t4_ack1", 32'(div_ack), 32'd0);
      chk("t4_clk1", 32'(clk_out), 32'd1);
      div_val = 8'd0;
      step_clk();
      div_load = 1'b0;
      chk("t4_err0", 32'(div_err), 32'd1);
      chk("t4_ack0", 32'(div_ack), 32'd0);
      check_period("t4", 3, 6, 2);

      // 5) loads 6 then 8 within one period; the second lands on the boundary edge
      div_load = 1'b1; div_val = 8'd6;
      step_clk();
      chk("t5_ack_mid", 32'(div_ack), 32'd0);
      chk("t5_tick",    32'(tick),    32'd1);
      div_val = 8'd8;
      step_clk();
      div_load = 1'b0;
      chk("t5_ack", 32'(div_ack), 32'd1);
      chk("t5_err", 32'(div_err), 32'd0);
      chk("t5_clk", 32'(clk_out), 32'd1);
      check_period("t5", 8, 16, 1);

      // 6) maximum divisor, mid-period abort, reset with a pending load
      do_reset();
      div_load = 1'b1; div_val = 8'd255;
      step_clk();
      div_load = 1'b0;
      chk("t6_ack_early", 32'(div_ack), 32'd0);
      step_clk();
      chk("t6_ack", 32'(div_ack), 32'd1);
      en = 1'b1;
      check_period("t6a", 255, 300, 0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_clk();
         chk("t6_idle_clk",  32'(clk_out), 32'd0);
         chk("t6_idle_tick", 32'(tick),    32'd0);
      end
      en = 1'b1;
      check_period("t6b", 255, 3, 0);
      div_load = 1'b1; div_val = 8'd6;
      step_clk();
      div_load = 1'b0;
      chk("t6_pend_ack", 32'(div_ack), 32'd0);
      reset = 1'b1; en = 1'b0;
      step_clk();
      chk("t6_rst_clk",  32'(clk_out), 32'd0);
      chk("t6_rst_tick", 32'(tick),    32'd0);
      chk("t6_rst_ack",  32'(div_ack), 32'd0);
      chk("t6_rst_err",  32'(div_err), 32'd0);
      reset = 1'b0;
      en = 1'b1;
      check_period("t6c", 4, 8, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
